fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS core. It owns the PC and drives the instruction-memory address. It latches the fetched word and PC+4 into IF/ID, which feed the decode control unit. It also produces that unit's `Stall` input from load-use hazard detection and pipeline bubbles, and it applies branch/jump redirects coming back from the execute stage.

---
 rtl/fetch_stage.sv | 116 +++++++++++
 tb/tb_fetch_stage.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage plus IF/ID pipeline register of the pipelined
//   MIPS core. Owns the PC, drives the instruction-memory address, latches
//   the fetched word and PC+4 into IF/ID, applies EX-stage redirects, and
//   produces the decode control unit's Stall input.
//
//   Build option: define FETCH_LOADUSE_STALL_EN to enable load-use hazard
//   detection. Without it, ex_memtoreg/ex_rt are ignored and software must
//   schedule a delay slot after each LW.
//
// Parameters:
//   RESET_PC    PC value loaded on reset
//   NOP_WORD    instruction word held in IF/ID while it is invalid
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst          in   1   synchronous active-high reset
//   imem_addr    out  32  current PC to combinational instruction memory
//   imem_data    in   32  instruction at imem_addr, same cycle
//   redirect_en  in   1   taken branch/jump resolved in EX
//   redirect_pc  in   32  redirect target (bits [1:0] forced to 0)
//   ex_memtoreg  in   1   ID/EX instruction is a load
//   ex_rt        in   5   destination register of that load
//   ins          out  32  IF/ID instruction
//   id_pc4       out  32  IF/ID PC+4
//   id_valid     out  1   IF/ID holds a real instruction
//   stall        out  1   squashes decoded controls to a bubble

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        ex_memtoreg,
    input  logic [4:0]  ex_rt,
    output logic [31:0] ins,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic        stall
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        hazard;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;   // wraps modulo 2^32

`ifdef FETCH_LOADUSE_STALL_EN
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;

    assign op = ins[31:26];
    assign rs = ins[25:21];
    assign rt = ins[20:16];

    always_comb begin
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        case (op)
            OP_RTYPE: begin uses_rs = 1'b1; uses_rt = 1'b1; end
            OP_LW:    begin uses_rs = 1'b1; end
            OP_SW:    begin uses_rs = 1'b1; uses_rt = 1'b1; end
            OP_BEQ:   begin uses_rs = 1'b1; uses_rt = 1'b1; end
            default:  begin uses_rs = 1'b0; uses_rt = 1'b0; end
        endcase
    end

    // No internal hazard state: the bubble this stall inserts into ID/EX
    // clears ex_memtoreg on the next edge, so the stall lasts one cycle.
    assign hazard = id_valid && ex_memtoreg && (ex_rt != 5'd0) &&
                    ((uses_rs && (ex_rt == rs)) || (uses_rt && (ex_rt == rt)));
`else
    logic unused_hazard_inputs;

    assign unused_hazard_inputs = ^{ex_memtoreg, ex_rt,
                                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ};
    assign hazard = 1'b0;
`endif

    assign stall = hazard || !id_valid;

    // Redirect outranks hazard: the stalled instruction is on the wrong
    // path anyway, so it is discarded rather than held.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            ins      <= NOP_WORD;
            id_pc4   <= '0;
            id_valid <= 1'b0;
        end else if (redirect_en) begin
            pc       <= {redirect_pc[31:2], 2'b00};
            ins      <= NOP_WORD;
            id_valid <= 1'b0;
        end else if (!hazard) begin
            pc       <= pc_plus4;
            ins      <= imem_data;
            id_pc4   <= pc_plus4;
            id_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'hDEAD_0000;
`ifdef FETCH_LOADUSE_STALL_EN
    localparam bit HZ_EN = 1'b1;
`else
    localparam bit HZ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        ex_memtoreg;
    logic [4:0]  ex_rt;
    logic [31:0] ins;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic        stall;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [31:0] m_pc, m_ins, m_pc4;
    logic        m_valid;
    bit          m_known = 1'b0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RST_PC), .NOP_WORD(NOP)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .ex_memtoreg(ex_memtoreg), .ex_rt(ex_rt), .ins(ins),
        .id_pc4(id_pc4), .id_valid(id_valid), .stall(stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Load-use hazard from the architectural rule: which source registers
    // the IF/ID opcode reads, against the in-flight load's destination.
    function automatic bit m_hazard();
        logic [5:0] op;
        bit rd_rs, rd_rt;
        op    = m_ins[31:26];
        rd_rs = (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04);
        rd_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
        if (!HZ_EN || !m_valid || !ex_memtoreg || ex_rt == 5'd0) return 1'b0;
        return (rd_rs && ex_rt == m_ins[25:21]) || (rd_rt && ex_rt == m_ins[20:16]);
    endfunction

    function automatic logic [31:0] m_stall();
        return {31'b0, m_hazard() || !m_valid};
    endfunction

    task automatic cycle(input logic r, input logic re, input logic [31:0] rp,
                         input logic em, input logic [4:0] er, input logic [31:0] d);
        bit hz;
        rst = r; redirect_en = re; redirect_pc = rp;
        ex_memtoreg = em; ex_rt = er; imem_data = d;
        #1;
        if (m_known) begin
            chk("imem_addr_pre", imem_addr, m_pc);
            chk("stall_pre", {31'b0, stall}, m_stall());
        end
        hz = m_known && m_hazard();
        if (r) begin
            m_pc = RST_PC; m_ins = NOP; m_pc4 = '0; m_valid = 1'b0; m_known = 1'b1;
        end else if (re) begin
            m_pc = rp & 32'hFFFF_FFFC; m_ins = NOP; m_valid = 1'b0;
        end else if (!hz) begin
            m_pc4 = m_pc + 32'd4; m_ins = d; m_pc = m_pc + 32'd4; m_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        if (m_known) begin
            chk("imem_addr", imem_addr, m_pc);
            chk("ins", ins, m_ins);
            chk("id_pc4", id_pc4, m_pc4);
            chk("id_valid", {31'b0, id_valid}, {31'b0, m_valid});
            chk("stall", {31'b0, stall}, m_stall());
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_word();
        logic [5:0] op;
        case ($urandom_range(0, 5))
            0: op = 6'h00;
            1: op = 6'h23;
            2: op = 6'h2B;
            3: op = 6'h04;
            4: op = 6'h02;
            default: op = 6'($urandom);
        endcase
        return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
    endfunction

    initial begin
        // Reset
        cycle(1, 0, 0, 0, 0, 0);
        chk("reset_addr", imem_addr, 32'h0000_0100);
        chk("reset_stall", {31'b0, stall}, 32'd1);
        chk("reset_ins", ins, 32'hDEAD_0000);

        // First fetch: lw $8,4($0)
        cycle(0, 0, 0, 0, 0, 32'h8C08_0004);
        chk("first_ins", ins, 32'h8C08_0004);
        chk("first_pc4", id_pc4, 32'h0000_0104);

        // add $10,$8,$9 enters IF/ID, then load-use on rs
        cycle(0, 0, 0, 0, 0, 32'h0109_5020);
        cycle(0, 0, 0, 1, 5'd8, 32'h1111_1111);
        cycle(0, 0, 0, 0, 5'd8, 32'h2222_2222);

        // J with ex_rt=8: no hazard
        cycle(0, 0, 0, 0, 0, 32'h0800_0010);
        cycle(0, 0, 0, 1, 5'd8, 32'h0000_4020);
        // add $8,$0,$0 with ex_rt=0: no hazard
        cycle(0, 0, 0, 1, 5'd0, 32'h0109_5020);

        // Redirect while hazard on add (rt=$9); low target bits dropped
        cycle(0, 1, 32'h0000_0043, 1, 5'd9, 32'h3333_3333);
        chk("redir_addr", imem_addr, 32'h0000_0040);
        chk("redir_valid", {31'b0, id_valid}, 32'd0);
        cycle(0, 0, 0, 0, 0, 32'h4444_4444);
        chk("redir_pc4", id_pc4, 32'h0000_0044);

        // PC wrap
        cycle(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 32'h5555_5555);
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        chk("wrap_pc4", id_pc4, 32'h0000_0000);

        // Reset while hazard pending
        cycle(0, 0, 0, 0, 0, 32'h0109_5020);
        cycle(1, 0, 0, 1, 5'd8, 32'h6666_6666);
        chk("rst_stall_addr", imem_addr, 32'h0000_0100);
        chk("rst_stall_pc4", id_pc4, 32'h0000_0000);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 9) == 0),
                  $urandom,
                  1'($urandom),
                  5'($urandom_range(0, 3)),
                  rand_word());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
